irq_arbiter: RTL and testbench

Platform-level external interrupt arbiter for the RV32I core. It collects `NUM_SRC` edge-triggered device interrupt lines and picks the highest-priority enabled pending source above a programmable threshold. It drives the core's machine external interrupt input (`meip`) and auto-claims the winning source when the CSR unit pulses `irq_ack`. Software configures it and signals completion through a small memory-mapped register port on the data bus.

---
 rtl/irq_pkg.sv | 28 ++
 rtl/irq_prio_select.sv | 32 +++
 rtl/irq_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_irq_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the external interrupt arbiter.
// Holds the per-source state encoding, the register map offsets and the ID width.
// The arbiter top and its priority selector both import this package.
package irq_pkg;

    // Lifecycle of one interrupt source.
    typedef enum logic [1:0] {
        SRC_IDLE       = 2'd0,
        SRC_PENDING    = 2'd1,
        SRC_IN_SERVICE = 2'd2
    } src_state_t;

    // Source ID width. ID 0 means "no source", so source i reports ID i+1.
    localparam int ID_W = 5;

    // Register map byte offsets. Bits [1:0] of the bus address are ignored.
    localparam logic [5:0] REG_PENDING   = 6'h00;
    localparam logic [5:0] REG_ENABLE    = 6'h04;
    localparam logic [5:0] REG_THRESHOLD = 6'h08;
    localparam logic [5:0] REG_CLAIM     = 6'h0C;
    localparam logic [5:0] REG_PRIO_BASE = 6'h10;

    // Word index of a byte offset; this is how the register port decodes.
    function automatic logic [3:0] word_idx(input logic [5:0] byte_addr);
        return byte_addr[5:2];
    endfunction

endpackage

// File: rtl/irq_prio_select.sv
// Combinational winner selection for the interrupt arbiter.
// Ports: i_cand (one bit per candidate source), i_prio (packed per-source priorities),
//        o_win_id (ID of the highest-priority candidate, lowest index on ties, 0 if none).
module irq_prio_select
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic [NUM_SRC-1:0]        i_cand,
    input  logic [NUM_SRC*PRIO_W-1:0] i_prio,
    output logic [ID_W-1:0]           o_win_id
);

    logic [PRIO_W-1:0] w_best_prio;

    // Scan in ascending index order and replace the current best only on a
    // strictly greater priority, so ties resolve to the lowest index. Every
    // candidate already has priority above the threshold, hence above 0, so
    // starting from priority 0 never lets a non-candidate win.
    always_comb begin
        w_best_prio = '0;
        o_win_id    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_cand[i] && (i_prio[i*PRIO_W +: PRIO_W] > w_best_prio)) begin
                w_best_prio = i_prio[i*PRIO_W +: PRIO_W];
                o_win_id    = ID_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Platform external interrupt arbiter: edge-triggered sources, per-source
// pending/in-service tracking, threshold masking, auto-claim on irq_ack.
// Ports: clk/reset (async active-high); src_i device lines; bus_* register port
//        with combinational bus_rdata; irq_ack from the CSR unit; meip request
//        and claim_id of the last claimed source, both registered.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               bus_sel,
    input  logic               bus_we,
    input  logic [5:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    input  logic               irq_ack,
    output logic               meip,
    output logic [4:0]         claim_id
);

    localparam int PRIO_WORD0 = int'(word_idx(REG_PRIO_BASE));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    src_state_t                r_state [NUM_SRC];
    logic [NUM_SRC-1:0]        r_again;
    logic [NUM_SRC-1:0]        r_src_q;
    logic [NUM_SRC-1:0]        r_enable;
    logic [PRIO_W-1:0]         r_threshold;
    logic [NUM_SRC*PRIO_W-1:0] r_prio;
    logic [ID_W-1:0]           r_best_id;
    logic                      r_meip;
    logic [ID_W-1:0]           r_claim_id;

    src_state_t                w_state_nxt [NUM_SRC];
    logic [NUM_SRC-1:0]        w_again_nxt;
    logic [NUM_SRC-1:0]        w_edge;
    logic [NUM_SRC-1:0]        w_claim;
    logic [NUM_SRC-1:0]        w_complete;
    logic [NUM_SRC-1:0]        w_pending;
    logic [NUM_SRC-1:0]        w_cand;
    logic [ID_W-1:0]           w_win_id;
    logic                      w_claim_fire;
    logic                      w_wr;
    logic [3:0]                w_word;
    logic [31:0]               w_rdata;
    logic                      w_unused;

    assign w_unused = ^bus_addr[1:0];

    assign w_wr   = bus_sel & bus_we;
    assign w_word = bus_addr[5:2];
    assign w_edge = src_i & ~r_src_q;

    // A claim only happens against the registered winner; an ack while no
    // winner is registered does nothing.
    assign w_claim_fire = irq_ack && (r_best_id != '0);

    // Per-source event decode. Comparing the full write word against i+1
    // rejects ID 0 and anything above NUM_SRC without a separate range check.
    always_comb begin
        w_claim    = '0;
        w_complete = '0;
        w_pending  = '0;
        w_cand     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_claim[i]    = w_claim_fire && (r_best_id == ID_W'(i + 1));
            w_complete[i] = w_wr && (w_word == word_idx(REG_CLAIM))
                            && (bus_wdata == 32'(i + 1))
                            && (r_state[i] == SRC_IN_SERVICE);
            w_pending[i]  = (r_state[i] == SRC_PENDING);
            w_cand[i]     = w_pending[i] && r_enable[i]
                            && (r_prio[i*PRIO_W +: PRIO_W] > r_threshold);
        end
    end

    // ------------------------------------------------------------------
    // Per-source FSM, next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_state_nxt[i] = r_state[i];
            w_again_nxt[i] = r_again[i];
            case (r_state[i])
                SRC_IDLE: begin
                    if (w_edge[i]) begin
                        w_state_nxt[i] = SRC_PENDING;
                    end
                end
                SRC_PENDING: begin
                    // Edges while pending coalesce, except that an edge landing
                    // on the claim edge is remembered for the next round.
                    if (w_claim[i]) begin
                        w_state_nxt[i] = SRC_IN_SERVICE;
                        w_again_nxt[i] = w_edge[i];
                    end
                end
                SRC_IN_SERVICE: begin
                    if (w_complete[i]) begin
                        // An edge arriving on the completion edge counts the
                        // same as one recorded earlier in the service window.
                        w_state_nxt[i] = (r_again[i] || w_edge[i]) ? SRC_PENDING : SRC_IDLE;
                        w_again_nxt[i] = 1'b0;
                    end else if (w_edge[i]) begin
                        w_again_nxt[i] = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i] = SRC_IDLE;
                    w_again_nxt[i] = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_state[i] <= SRC_IDLE;
            end
            r_again <= '0;
            r_src_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
            r_again <= w_again_nxt;
            r_src_q <= src_i;
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable    <= '0;
            r_threshold <= '0;
            r_prio      <= '0;
        end else if (w_wr) begin
            if (w_word == word_idx(REG_ENABLE)) begin
                r_enable <= bus_wdata[NUM_SRC-1:0];
            end
            if (w_word == word_idx(REG_THRESHOLD)) begin
                r_threshold <= bus_wdata[PRIO_W-1:0];
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (int'(w_word) == PRIO_WORD0 + i) begin
                    r_prio[i*PRIO_W +: PRIO_W] <= bus_wdata[PRIO_W-1:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Winner selection and request/claim registers
    // ------------------------------------------------------------------
    irq_prio_select #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_prio_select (
        .i_cand   (w_cand),
        .i_prio   (r_prio),
        .o_win_id (w_win_id)
    );

    // The claim edge blanks the request for one cycle so the CSR unit never
    // sees the just-claimed source as still requesting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_best_id  <= '0;
            r_meip     <= 1'b0;
            r_claim_id <= '0;
        end else begin
            if (w_claim_fire) begin
                r_best_id  <= '0;
                r_meip     <= 1'b0;
                r_claim_id <= r_best_id;
            end else begin
                r_best_id  <= w_win_id;
                r_meip     <= (w_win_id != '0);
            end
        end
    end

    assign meip     = r_meip;
    assign claim_id = r_claim_id;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (bus_sel) begin
            if (w_word == word_idx(REG_PENDING)) begin
                w_rdata[NUM_SRC-1:0] = w_pending;
            end else if (w_word == word_idx(REG_ENABLE)) begin
                w_rdata[NUM_SRC-1:0] = r_enable;
            end else if (w_word == word_idx(REG_THRESHOLD)) begin
                w_rdata[PRIO_W-1:0] = r_threshold;
            end else if (w_word == word_idx(REG_CLAIM)) begin
                w_rdata[ID_W-1:0] = r_claim_id;
            end else begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (int'(w_word) == PRIO_WORD0 + i) begin
                        w_rdata[PRIO_W-1:0] = r_prio[i*PRIO_W +: PRIO_W];
                    end
                end
            end
        end
    end

    assign bus_rdata = w_rdata;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter with a claim-order scoreboard.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Expected claim IDs are queued when sources fire and popped on each ack.
module tb_irq_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  src_i = '0;
    logic        bus_sel = 1'b0;
    logic        bus_we = 1'b0;
    logic [5:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        irq_ack = 1'b0;
    logic        meip;
    logic [4:0]  claim_id;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned sb[$];

    irq_arbiter #(.NUM_SRC(8), .PRIO_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_i     (src_i),
        .bus_sel   (bus_sel),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .irq_ack   (irq_ack),
        .meip      (meip),
        .claim_id  (claim_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        bus_sel   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        tick();
        bus_sel   = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = '0;
    endtask

    task automatic bus_check(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_sel  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = a;
        #1;
        d = bus_rdata;
        bus_sel = 1'b0;
        check(tag, d, exp);
    endtask

    task automatic pulse(input logic [7:0] mask);
        src_i = mask;
        tick();
        src_i = '0;
    endtask

    // Ack and compare claim_id against the next scoreboard entry.
    task automatic do_ack(input string tag);
        int unsigned e;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check(tag, 32'(claim_id), e);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b1;
        tick();
        tick();
        check("rst_meip", 32'(meip), 32'd0);
        check("rst_claim", 32'(claim_id), 32'd0);
        bus_check("rst_enable", 6'h04, 32'd0);
        bus_check("rst_pending", 6'h00, 32'd0);
        reset = 1'b0;
        tick();

        // ---------------- single source, 2-cycle latency ----------------
        bus_write(6'h04, 32'h01);
        bus_write(6'h10, 32'd3);
        bus_write(6'h08, 32'd0);
        bus_check("rd_prio0", 6'h10, 32'd3);
        pulse(8'h01);
        check("lat_meip_e0", 32'(meip), 32'd0);
        tick();
        check("lat_meip_e1", 32'(meip), 32'd1);
        bus_check("pending_s0", 6'h00, 32'h1);
        sb.push_back(1);
        do_ack("claim_s0");
        check("ack_meip_drop", 32'(meip), 32'd0);
        bus_check("pending_after_claim", 6'h00, 32'h0);
        bus_check("rd_claim", 6'h0C, 32'd1);
        bus_write(6'h0C, 32'd1);
        tick();
        check("idle_meip", 32'(meip), 32'd0);
        #1;
        check("rdata_unsel", bus_rdata, 32'd0);

        // ---------------- priority ordering ----------------
        bus_write(6'h04, 32'h24);
        bus_write(6'h18, 32'd4);
        bus_write(6'h24, 32'd6);
        pulse(8'h24);
        sb.push_back(6);
        sb.push_back(3);
        tick();
        check("prio_meip", 32'(meip), 32'd1);
        do_ack("claim_prio_hi");
        check("prio_meip_drop", 32'(meip), 32'd0);
        tick();
        check("prio_meip_reassert", 32'(meip), 32'd1);
        do_ack("claim_prio_lo");
        check("prio_meip_done", 32'(meip), 32'd0);
        bus_write(6'h0C, 32'd6);
        bus_write(6'h0C, 32'd3);
        bus_check("prio_pending_clear", 6'h00, 32'h0);

        // ---------------- tie break and threshold ----------------
        bus_write(6'h04, 32'h0A);
        bus_write(6'h14, 32'd2);
        bus_write(6'h1C, 32'd2);
        pulse(8'h0A);
        sb.push_back(2);
        sb.push_back(4);
        tick();
        do_ack("claim_tie_lo");
        tick();
        do_ack("claim_tie_hi");
        bus_write(6'h0C, 32'd2);
        bus_write(6'h0C, 32'd4);
        bus_write(6'h08, 32'd2);
        pulse(8'h0A);
        tick();
        tick();
        check("thresh_masked", 32'(meip), 32'd0);
        bus_check("thresh_pending", 6'h00, 32'h0A);
        bus_write(6'h08, 32'd1);
        tick();
        check("thresh_lowered", 32'(meip), 32'd1);
        sb.push_back(2);
        sb.push_back(4);
        do_ack("claim_thr_a");
        tick();
        do_ack("claim_thr_b");
        bus_write(6'h0C, 32'd2);
        bus_write(6'h0C, 32'd4);

        // ---------------- re-trigger during service ----------------
        bus_write(6'h04, 32'h01);
        pulse(8'h01);
        tick();
        sb.push_back(1);
        do_ack("claim_again");
        pulse(8'h01);
        check("again_in_service", 32'(meip), 32'd0);
        bus_write(6'h0C, 32'd1);
        check("again_complete_edge", 32'(meip), 32'd0);
        tick();
        check("again_repend", 32'(meip), 32'd1);
        bus_write(6'h0C, 32'd7);
        bus_write(6'h0C, 32'd0);
        bus_write(6'h0C, 32'd9);
        bus_check("bad_complete_pending", 6'h00, 32'h01);
        check("bad_complete_meip", 32'(meip), 32'd1);
        // Edge on the same edge as the claim: remembered as "again".
        src_i = 8'h01;
        sb.push_back(1);
        do_ack("claim_with_edge");
        src_i = '0;
        bus_write(6'h0C, 32'd1);
        tick();
        check("edge_claim_repend", 32'(meip), 32'd1);
        sb.push_back(1);
        do_ack("claim_final");
        bus_write(6'h0C, 32'd1);
        tick();
        check("final_idle_meip", 32'(meip), 32'd0);
        bus_check("final_pending", 6'h00, 32'h0);

        // ---------------- reset mid-service ----------------
        bus_write(6'h04, 32'h11);
        bus_write(6'h20, 32'd5);
        pulse(8'h10);
        tick();
        sb.push_back(5);
        do_ack("claim_s4");
        pulse(8'h01);
        tick();
        check("pre_reset_meip", 32'(meip), 32'd1);
        reset = 1'b1;
        src_i = 8'h10;
        #1;
        check("async_rst_meip", 32'(meip), 32'd0);
        check("async_rst_claim", 32'(claim_id), 32'd0);
        tick();
        tick();
        check("hold_rst_meip", 32'(meip), 32'd0);
        bus_check("hold_rst_enable", 6'h04, 32'd0);
        bus_check("hold_rst_thresh", 6'h08, 32'd0);
        bus_check("hold_rst_prio4", 6'h20, 32'd0);
        bus_check("hold_rst_pending", 6'h00, 32'd0);
        reset = 1'b0;
        tick();
        bus_check("held_src_edge", 6'h00, 32'h10);
        check("post_rst_meip", 32'(meip), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
